// File: rtl/addsub_serial.sv
// addsub_serial
//   Multi-cycle two's-complement adder/subtractor. A WIDTH-bit operand pair is
//   processed SLICE bits per clock, LSB slice first, with the ripple carry held
//   in a register between slices. ctrl=0 adds, ctrl=1 subtracts (B inverted,
//   carry-in forced to 1).
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready operand handshake (in_ready high only in IDLE)
//   a, b, ctrl        operands and operation select, sampled on accept
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   s                 sum/difference modulo 2^WIDTH
//   c                 carry out of MSB (subtract: 1 = no borrow)
//   ovf               signed overflow (carry into MSB ^ carry out of MSB)
//   zero              s == 0
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for in_valid; operands are latched on acceptance
// RUN   | one slice per cycle; results committed on the last slice
// DONE  | result valid; held until out_ready
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;     // already conditionally inverted
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] acc_q, acc_d; // working sum, separate from s so s only
                                  // changes on completion
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [SLICE-1:0] a_sl, b_sl;
  logic [SLICE:0]   sl_sum;
  logic             msb_cin;
  int unsigned      off;

  always_comb begin
    off     = int'(idx_q) * SLICE;
    a_sl    = a_q[off +: SLICE];
    b_sl    = b_q[off +: SLICE];
    sl_sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
    // Carry into the top bit of the slice, recovered from the sum bit.
    msb_cin = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ sl_sum[SLICE-1];

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    s_d     = s_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{ctrl}};
          carry_d = ctrl;
          idx_d   = '0;
          acc_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d[off +: SLICE] = sl_sum[SLICE-1:0];
        carry_d             = sl_sum[SLICE];
        if (idx_q == LAST) begin
          s_d     = acc_d;
          c_d     = sl_sum[SLICE];
          ovf_d   = msb_cin ^ sl_sum[SLICE];
          zero_d  = (acc_d == '0);
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign s         = s_q;
  assign c         = c_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial: three instances (SLICE = 4, 1, 16) share
// operands and reset; each has its own in_valid/out_ready.
module tb_addsub_serial;

  logic        clk;
  logic        rst_n;
  logic [15:0] a, b;
  logic        ctrl;
  logic [2:0]  iv, ordy;
  logic [2:0]  irdy, ov, cw, ow, zw;
  logic [15:0] s_w [3];
  logic [15:0] last_s [3];

  int passed = 0;
  int total  = 0;

  addsub_serial #(.WIDTH(16), .SLICE(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
    .a(a), .b(b), .ctrl(ctrl), .out_valid(ov[0]), .out_ready(ordy[0]),
    .s(s_w[0]), .c(cw[0]), .ovf(ow[0]), .zero(zw[0]));

  addsub_serial #(.WIDTH(16), .SLICE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
    .a(a), .b(b), .ctrl(ctrl), .out_valid(ov[1]), .out_ready(ordy[1]),
    .s(s_w[1]), .c(cw[1]), .ovf(ow[1]), .zero(zw[1]));

  addsub_serial #(.WIDTH(16), .SLICE(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
    .a(a), .b(b), .ctrl(ctrl), .out_valid(ov[2]), .out_ready(ordy[2]),
    .s(s_w[2]), .c(cw[2]), .ovf(ow[2]), .zero(zw[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on instance sel with a fixed latency in cycles.
  task automatic do_op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                       input logic cv, input logic [15:0] es, input logic ec,
                       input logic eo, input logic ez, input int lat, input string tag);
    a = av; b = bv; ctrl = cv;
    iv[sel] = 1'b1;
    step();                       // accept edge E0
    iv[sel] = 1'b0;
    chk({tag, "_inrdy_busy"}, irdy[sel], 0);
    for (int i = 1; i <= lat; i++) begin
      chk({tag, "_ov_early"}, ov[sel], 0);
      chk({tag, "_s_hold_run"}, s_w[sel], last_s[sel]);
      a = ~a; b = b + 16'h1111; ctrl = ~ctrl;   // must be ignored
      step();
    end
    chk({tag, "_ov"},   ov[sel], 1);
    chk({tag, "_s"},    s_w[sel], es);
    chk({tag, "_c"},    cw[sel], ec);
    chk({tag, "_ovf"},  ow[sel], eo);
    chk({tag, "_zero"}, zw[sel], ez);
    ordy[sel] = 1'b1;
    step();
    ordy[sel] = 1'b0;
    chk({tag, "_ov_drop"}, ov[sel], 0);
    chk({tag, "_inrdy_back"}, irdy[sel], 1);
    chk({tag, "_s_keep"}, s_w[sel], es);
    last_s[sel] = es;
  endtask

  initial begin
    rst_n = 1'b0; iv = '0; ordy = '0; a = '0; b = '0; ctrl = 1'b0;
    for (int i = 0; i < 3; i++) last_s[i] = '0;
    #2;
    chk("rst_inrdy", irdy[0], 1);
    chk("rst_ov",    ov[0], 0);
    chk("rst_s",     s_w[0], 0);
    chk("rst_flags", {cw[0], ow[0], zw[0]}, 0);
    step();
    rst_n = 1'b1;
    step();

    // out_ready outside DONE must do nothing
    ordy[0] = 1'b1; step(); ordy[0] = 1'b0;
    chk("idle_ordy_ov", ov[0], 0);

    do_op(0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0, 4, "add");
    do_op(0, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 4, "sub_borrow");
    do_op(0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 4, "add_ovf");
    do_op(0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4, "add_wrap");
    do_op(0, 16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 4, "sub_eq");
    do_op(0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 4, "sub_ovf");

    // Backpressure: 0x00FF + 0x0001 = 0x0100, held in DONE for 10 cycles
    a = 16'h00FF; b = 16'h0001; ctrl = 1'b0; iv[0] = 1'b1;
    step();
    a = 16'hAAAA; b = 16'h5555;
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 10; i++) begin
      chk("bp_ov",    ov[0], 1);
      chk("bp_inrdy", irdy[0], 0);
      chk("bp_s",     s_w[0], 16'h0100);
      chk("bp_flags", {cw[0], ow[0], zw[0]}, 0);
      a = a + 16'h0123; b = b ^ 16'h0F0F; ctrl = ~ctrl;
      step();
    end
    // Consume with in_valid still high: only the result goes
    a = 16'h0003; b = 16'h0002; ctrl = 1'b1; ordy[0] = 1'b1;
    step();
    ordy[0] = 1'b0;
    chk("bp_consume_ov", ov[0], 0);
    chk("bp_consume_idle", irdy[0], 1);
    chk("bp_consume_s", s_w[0], 16'h0100);
    // Operands present at the real accept edge: 0x0010 - 0x0003 = 0x000D
    a = 16'h0010; b = 16'h0003; ctrl = 1'b1;
    step();
    iv[0] = 1'b0;
    a = 16'hFFFF; b = 16'hFFFF; ctrl = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_next_early", ov[0], 0);
      step();
    end
    chk("bp_next_early", ov[0], 0);
    step();
    chk("bp_next_ov", ov[0], 1);
    chk("bp_next_s", s_w[0], 16'h000D);
    chk("bp_next_flags", {cw[0], ow[0], zw[0]}, 3'b100);
    ordy[0] = 1'b1; step(); ordy[0] = 1'b0;

    // Reset after two RUN cycles
    a = 16'h1234; b = 16'h0FCD; ctrl = 1'b0; iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", ov[0], 0);
    chk("mid_rst_s", s_w[0], 0);
    chk("mid_rst_flags", {cw[0], ow[0], zw[0]}, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_inrdy", irdy[0], 1);
    chk("post_rst_ov", ov[0], 0);
    for (int i = 0; i < 3; i++) last_s[i] = '0;

    do_op(0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0, 4,  "add_after_rst");
    do_op(1, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0, 16, "add_slice1");
    do_op(2, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0, 1,  "add_slice16");
    do_op(1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 16, "sub_ovf_slice1");
    do_op(2, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1,  "add_wrap_slice16");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
